// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the execute stage: instruction codes, ALU
// functions, jump/cmov conditions, status codes and the M-register bubble.
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;  // also CMOVXX
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // ALU functions (ifun of OPQ)
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  // Conditions (ifun of JXX / CMOVXX)
  localparam logic [3:0] C_ALWAYS = 4'h0;
  localparam logic [3:0] C_LE     = 4'h1;
  localparam logic [3:0] C_L      = 4'h2;
  localparam logic [3:0] C_E      = 4'h3;
  localparam logic [3:0] C_NE     = 4'h4;
  localparam logic [3:0] C_GE     = 4'h5;
  localparam logic [3:0] C_G      = 4'h6;

  // Status codes
  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 4'd4;

  localparam logic [3:0] RNONE = 4'hF;

  // Bubble contents of the M register (a NOP that writes nothing)
  localparam logic [2:0] BUBBLE_STAT  = S_AOK;
  localparam logic [3:0] BUBBLE_ICODE = I_NOP;

  // Reset value of {ZF,SF,OF}
  localparam logic [2:0] CC_RESET = 3'b100;

  // An instruction further down the pipe that has faulted or halted must
  // not see its effects overtaken by a younger OPQ changing the flags.
  function automatic logic stat_is_exc(input logic [2:0] s);
    return (s == S_ADR) || (s == S_INS) || (s == S_HLT);
  endfunction

endpackage

// File: rtl/y86_alu.sv
// Combinational Y86-64 ALU: result = b OP a, plus {ZF,SF,OF} for that result.
module y86_alu
  import y86_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   fn,
  output logic [W-1:0] res,
  output logic         zf,
  output logic         sf,
  output logic         of
);

  // Operation select and flag generation; unknown functions give zero.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    res = '0;
    of  = 1'b0;
    unique case (fn)
      ALU_ADD: begin
        res = b + a;
        of  = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
      end
      ALU_SUB: begin
        res = b - a;
        of  = (a[W-1] != b[W-1]) && (res[W-1] != b[W-1]);
      end
      ALU_AND: res = b & a;
      ALU_XOR: res = b ^ a;
      default: ;
    endcase
    zf = (res == '0);
    sf = res[W-1];
  end

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: operand selection, ALU, condition codes, branch/cmov
// condition, forwarding outputs, and the E->M pipeline register.
module execute_stage
  import y86_pkg::*;
#(
  parameter int W      = 64,
  parameter int STAT_W = 3,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [STAT_W-1:0] E_stat,
  input  logic [3:0]        E_icode,
  input  logic [3:0]        E_ifun,
  input  logic [W-1:0]      E_valC,
  input  logic [W-1:0]      E_valA,
  input  logic [W-1:0]      E_valB,
  input  logic [REG_W-1:0]  E_destE,
  input  logic [REG_W-1:0]  E_destM,
  input  logic [STAT_W-1:0] m_stat,
  input  logic [STAT_W-1:0] W_stat,
  input  logic              M_bubble,
  output logic [W-1:0]      e_valE,
  output logic [REG_W-1:0]  e_dstE,
  output logic              e_Cnd,
  output logic [2:0]        cc,
  output logic [STAT_W-1:0] M_stat,
  output logic [3:0]        M_icode,
  output logic              M_Cnd,
  output logic [W-1:0]      M_valE,
  output logic [W-1:0]      M_valA,
  output logic [REG_W-1:0]  M_dstE,
  output logic [REG_W-1:0]  M_dstM
);

  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [3:0]   alu_fn;
  logic         alu_zf, alu_sf, alu_of;
  logic         set_cc;
  logic         lt;

  // Operand and function selection by instruction class.
  always_comb begin
    alu_a = '0;
    alu_b = '0;
    unique case (E_icode)
      I_RRMOVQ:          alu_a = E_valA;
      I_OPQ:             begin alu_a = E_valA; alu_b = E_valB; end
      I_IRMOVQ:          alu_a = E_valC;
      I_RMMOVQ, I_MRMOVQ: begin alu_a = E_valC; alu_b = E_valB; end
      I_CALL, I_PUSHQ:   begin alu_a = -W'(8); alu_b = E_valB; end
      I_RET, I_POPQ:     begin alu_a = W'(8);  alu_b = E_valB; end
      default: ;
    endcase
    alu_fn = (E_icode == I_OPQ) ? E_ifun : ALU_ADD;
  end

  y86_alu #(.W(W)) u_alu (
    .a   (alu_a),
    .b   (alu_b),
    .fn  (alu_fn),
    .res (e_valE),
    .zf  (alu_zf),
    .sf  (alu_sf),
    .of  (alu_of)
  );

  // Flags change only for a valid OPQ while nothing older has faulted.
  assign set_cc = (E_icode == I_OPQ) && (E_ifun <= ALU_XOR) &&
                  !stat_is_exc(m_stat) && !stat_is_exc(W_stat);

  // Condition-code register {ZF,SF,OF}.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc <= CC_RESET;
    end else if (set_cc) begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      cc <= {alu_zf, alu_sf, alu_of};
    end
  end

  // Jump/cmov condition evaluated against the flags as they stand now.
  always_comb begin
    lt = cc[1] ^ cc[0];
    unique case (E_ifun)
      C_ALWAYS: e_Cnd = 1'b1;
      C_LE:     e_Cnd = lt | cc[2];
      C_L:      e_Cnd = lt;
      C_E:      e_Cnd = cc[2];
      C_NE:     e_Cnd = ~cc[2];
      C_GE:     e_Cnd = ~lt;
      C_G:      e_Cnd = ~lt & ~cc[2];
      default:  e_Cnd = 1'b0;
    endcase
  end

  // A cmov whose condition fails writes no register.
  assign e_dstE = (E_icode == I_RRMOVQ && !e_Cnd) ? RNONE : E_destE;

  // E->M pipeline register: reset and bubble both load a harmless NOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      M_stat  <= BUBBLE_STAT;
      M_icode <= BUBBLE_ICODE;
      M_Cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= RNONE;
      M_dstM  <= RNONE;
    end else if (M_bubble) begin
      M_stat  <= BUBBLE_STAT;
      M_icode <= BUBBLE_ICODE;
      M_Cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= RNONE;
      M_dstM  <= RNONE;
    end else begin
      M_stat  <= E_stat;
      M_icode <= E_icode;
      M_Cnd   <= e_Cnd;
      M_valE  <= e_valE;
      M_valA  <= E_valA;
      M_dstE  <= e_dstE;
      M_dstM  <= E_destM;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed cases with literal
// expectations, then randomized traffic against a behavioural model.
module tb_execute_stage;

  logic        clk;
  logic        rst_n;
  logic [2:0]  E_stat;
  logic [3:0]  E_icode;
  logic [3:0]  E_ifun;
  logic [63:0] E_valC;
  logic [63:0] E_valA;
  logic [63:0] E_valB;
  logic [3:0]  E_destE;
  logic [3:0]  E_destM;
  logic [2:0]  m_stat;
  logic [2:0]  W_stat;
  logic        M_bubble;
  logic [63:0] e_valE;
  logic [3:0]  e_dstE;
  logic        e_Cnd;
  logic [2:0]  cc;
  logic [2:0]  M_stat;
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;

  execute_stage dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .E_stat   (E_stat),
    .E_icode  (E_icode),
    .E_ifun   (E_ifun),
    .E_valC   (E_valC),
    .E_valA   (E_valA),
    .E_valB   (E_valB),
    .E_destE  (E_destE),
    .E_destM  (E_destM),
    .m_stat   (m_stat),
    .W_stat   (W_stat),
    .M_bubble (M_bubble),
    .e_valE   (e_valE),
    .e_dstE   (e_dstE),
    .e_Cnd    (e_Cnd),
    .cc       (cc),
    .M_stat   (M_stat),
    .M_icode  (M_icode),
    .M_Cnd    (M_Cnd),
    .M_valE   (M_valE),
    .M_valA   (M_valA),
    .M_dstE   (M_dstE),
    .M_dstM   (M_dstM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: flags and expected M register contents.
  logic [2:0]  mcc;
  logic [2:0]  xm_stat;
  logic [3:0]  xm_icode;
  logic        xm_cnd;
  logic [63:0] xm_valE;
  logic [63:0] xm_valA;
  logic [3:0]  xm_dstE;
  logic [3:0]  xm_dstM;

  // DUT combinational outputs sampled mid-cycle by the last step.
  logic [63:0] s_valE;
  logic [3:0]  s_dstE;
  logic        s_cnd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mcc      = 3'b100;
    xm_stat  = 3'd1;
    xm_icode = 4'h1;
    xm_cnd   = 1'b0;
    xm_valE  = 64'd0;
    xm_valA  = 64'd0;
    xm_dstE  = 4'hF;
    xm_dstM  = 4'hF;
  endtask

  // Architectural meaning of each instruction in the execute stage.
  task automatic model_exec(output logic [63:0] res, output logic cnd,
                            output logic [3:0] dst, output logic upd,
                            output logic [2:0] ncc);
    logic signed [64:0] wide;
    logic of;
    logic lt;
    res = 64'd0;
    of  = 1'b0;
    wide = '0;
    case (E_icode)
      4'h2: res = E_valA;
      4'h3: res = E_valC;
      4'h4, 4'h5: res = E_valB + E_valC;
      4'h6: begin
        case (E_ifun)
          4'h0: begin
            wide = $signed({E_valB[63], E_valB}) + $signed({E_valA[63], E_valA});
            res = wide[63:0];
            of = wide[64] != wide[63];
          end
          4'h1: begin
            wide = $signed({E_valB[63], E_valB}) - $signed({E_valA[63], E_valA});
            res = wide[63:0];
            of = wide[64] != wide[63];
          end
          4'h2: res = E_valA & E_valB;
          4'h3: res = E_valA ^ E_valB;
          default: res = 64'd0;
        endcase
      end
      4'h8, 4'hA: res = E_valB - 64'd8;
      4'h9, 4'hB: res = E_valB + 64'd8;
      default: res = 64'd0;
    endcase
    lt = (mcc[1] != mcc[0]);
    case (E_ifun)
      4'h0: cnd = 1'b1;
      4'h1: cnd = lt || mcc[2];
      4'h2: cnd = lt;
      4'h3: cnd = mcc[2];
      4'h4: cnd = !mcc[2];
      4'h5: cnd = !lt;
      4'h6: cnd = !lt && !mcc[2];
      default: cnd = 1'b0;
    endcase
    dst = (E_icode == 4'h2 && !cnd) ? 4'hF : E_destE;
    upd = (E_icode == 4'h6) && (E_ifun < 4'd4) &&
          !(m_stat >= 3'd2 && m_stat <= 3'd4) && !(W_stat >= 3'd2 && W_stat <= 3'd4);
    ncc = {res == 64'd0, res[63], of};
  endtask

  // One clock: check combinational outputs mid-cycle, advance the model,
  // then check the registered outputs just after the edge.
  task automatic step();
    logic [63:0] res;
    logic cnd, upd;
    logic [3:0] dst;
    logic [2:0] ncc;
    @(negedge clk);
    model_exec(res, cnd, dst, upd, ncc);
    s_valE = e_valE;
    s_dstE = e_dstE;
    s_cnd  = e_Cnd;
    check("e_valE", e_valE, res);
    check("e_dstE", 64'(e_dstE), 64'(dst));
    check("e_Cnd", 64'(e_Cnd), 64'(cnd));
    check("cc_pre", 64'(cc), 64'(mcc));
    if (M_bubble) begin
      xm_stat = 3'd1; xm_icode = 4'h1; xm_cnd = 1'b0;
      xm_valE = 64'd0; xm_valA = 64'd0; xm_dstE = 4'hF; xm_dstM = 4'hF;
    end else begin
      xm_stat = E_stat; xm_icode = E_icode; xm_cnd = cnd;
      xm_valE = res; xm_valA = E_valA; xm_dstE = dst; xm_dstM = E_destM;
    end
    if (upd) mcc = ncc;
    @(posedge clk);
    #1;
    check_m("post");
  endtask

  task automatic check_m(input string tag);
    check({tag, "_M_stat"}, 64'(M_stat), 64'(xm_stat));
    check({tag, "_M_icode"}, 64'(M_icode), 64'(xm_icode));
    check({tag, "_M_Cnd"}, 64'(M_Cnd), 64'(xm_cnd));
    check({tag, "_M_valE"}, M_valE, xm_valE);
    check({tag, "_M_valA"}, M_valA, xm_valA);
    check({tag, "_M_dstE"}, 64'(M_dstE), 64'(xm_dstE));
    check({tag, "_M_dstM"}, 64'(M_dstM), 64'(xm_dstM));
    check({tag, "_cc"}, 64'(cc), 64'(mcc));
  endtask

  task automatic drive(input logic [3:0] icode, input logic [3:0] ifun,
                       input logic [63:0] valc, input logic [63:0] vala,
                       input logic [63:0] valb, input logic [3:0] de,
                       input logic [3:0] dm, input logic [2:0] ms,
                       input logic [2:0] ws, input logic bub);
    E_stat = 3'd1; E_icode = icode; E_ifun = ifun; E_valC = valc;
    E_valA = vala; E_valB = valb; E_destE = de; E_destM = dm;
    m_stat = ms; W_stat = ws; M_bubble = bub;
  endtask

  // Assert reset a few ns after an edge, confirm it acts at once and
  // dominates the following edge, then release just after an edge.
  task automatic apply_reset(input string tag);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_m({tag, "_async"});
    @(posedge clk);
    #1;
    check_m({tag, "_hold"});
    rst_n = 1'b1;
  endtask

  function automatic logic [63:0] rand64();
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0: v = 64'd0;
      1: v = 64'd1;
      2: v = 64'h7FFF_FFFF_FFFF_FFFF;
      3: v = 64'h8000_0000_0000_0000;
      4: v = 64'hFFFF_FFFF_FFFF_FFFF;
      5: v = 64'($urandom_range(0, 255));
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  function automatic logic [2:0] rand_stat();
    return ($urandom_range(0, 9) < 7) ? 3'd1 : 3'($urandom_range(0, 7));
  endfunction

  initial begin
    rst_n = 1'b1;
    drive(4'h6, 4'h0, 64'h11, 64'h22, 64'h33, 4'h5, 4'h6, 3'd1, 3'd1, 1'b0);
    model_reset();
    #1;
    rst_n = 1'b0;
    #1;
    check_m("reset0");
    repeat (2) @(posedge clk);
    #1;
    check_m("reset0_hold");
    rst_n = 1'b1;

    // OPQ sub: 3 - 5
    drive(4'h6, 4'h1, 64'd0, 64'd5, 64'd3, 4'h2, 4'hF, 3'd1, 3'd1, 1'b0);
    step();
    check("lit_sub_valE", s_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    check("lit_sub_cc", 64'(cc), 64'(3'b010));
    check("lit_sub_M_valE", M_valE, 64'hFFFF_FFFF_FFFF_FFFE);

    // OPQ add with signed overflow
    drive(4'h6, 4'h0, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
          4'h2, 4'hF, 3'd1, 3'd1, 1'b0);
    step();
    check("lit_ovf_valE", s_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    check("lit_ovf_cc", 64'(cc), 64'(3'b011));

    // Clear flags with 1+1, then CMOVLE must fail
    drive(4'h6, 4'h0, 64'd0, 64'd1, 64'd1, 4'h2, 4'hF, 3'd1, 3'd1, 1'b0);
    step();
    check("lit_clr_cc", 64'(cc), 64'(3'b000));
    drive(4'h2, 4'h1, 64'd0, 64'h1234, 64'd0, 4'h3, 4'hF, 3'd1, 3'd1, 1'b0);
    step();
    check("lit_cmovle_cnd0", 64'(s_cnd), 64'd0);
    check("lit_cmovle_dstF", 64'(s_dstE), 64'hF);

    // Set ZF via xor, CMOVLE now takes
    drive(4'h6, 4'h3, 64'd0, 64'd7, 64'd7, 4'h2, 4'hF, 3'd1, 3'd1, 1'b0);
    step();
    check("lit_xor_cc", 64'(cc), 64'(3'b100));
    drive(4'h2, 4'h1, 64'd0, 64'h1234, 64'd0, 4'h3, 4'hF, 3'd1, 3'd1, 1'b0);
    step();
    check("lit_cmovle_cnd1", 64'(s_cnd), 64'd1);
    check("lit_cmovle_dst3", 64'(s_dstE), 64'h3);

    // Stack pointer arithmetic leaves flags alone
    drive(4'hA, 4'h0, 64'd0, 64'h55, 64'h100, 4'h4, 4'hF, 3'd1, 3'd1, 1'b0);
    step();
    check("lit_push_valE", s_valE, 64'hF8);
    drive(4'hB, 4'h0, 64'd0, 64'h55, 64'hF8, 4'h4, 4'h7, 3'd1, 3'd1, 1'b0);
    step();
    check("lit_pop_valE", s_valE, 64'h100);
    check("lit_pop_cc", 64'(cc), 64'(3'b100));

    // Exception in W blocks the flag update; bubble on the same edge
    drive(4'h6, 4'h3, 64'd0, 64'd1, 64'd2, 4'h2, 4'h5, 3'd1, 3'd3, 1'b1);
    step();
    check("lit_exc_cc", 64'(cc), 64'(3'b100));
    check("lit_bub_icode", 64'(M_icode), 64'h1);
    check("lit_bub_dstE", 64'(M_dstE), 64'hF);

    // Randomized traffic with a reset dropped in mid-stream
    for (int i = 0; i < 400; i++) begin
      logic [3:0] ic;
      logic [3:0] fn;
      ic = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(12, 15))
                                        : 4'($urandom_range(0, 11));
      fn = (ic == 4'h6) ? 4'($urandom_range(0, 5)) : 4'($urandom_range(0, 7));
      drive(ic, fn, rand64(), rand64(), rand64(), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), rand_stat(), rand_stat(),
            $urandom_range(0, 9) == 0);
      E_stat = 3'($urandom_range(1, 4));
      step();
      if (i == 200) apply_reset("reset_mid");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
